// File: rtl/n64_joybus_sniffer_if.sv
// n64_joybus_sniffer_if: consumer-side bundle of the passive Joybus sniffer
`timescale 1ns/1ps
interface n64_joybus_sniffer_if #(parameter int RESP_BYTES = 4);
  logic igr_en;
  logic [15:0] igr_pattern;
  logic ack;
  logic [RESP_BYTES*8-1:0] ctrl_data;
  logic data_valid;
  logic overrun;
  logic frame_err;
  logic igr_hit;
  logic [1:0] state_o;
  modport master(output igr_en, igr_pattern, ack,
                 input ctrl_data, data_valid, overrun, frame_err, igr_hit, state_o);
  modport slave(input igr_en, igr_pattern, ack,
                output ctrl_data, data_valid, overrun, frame_err, igr_hit, state_o);
endinterface

// File: rtl/n64_joybus_sniffer.sv
// n64_joybus_sniffer: passive Joybus decoder capturing the controller response to a poll command
`timescale 1ns/1ps
module n64_joybus_sniffer #(
  parameter int CNT_W = 6,
  parameter int RESP_BYTES = 4,
  parameter logic [7:0] CMD_POLL = 8'h01
) (
  input logic CLK_4M,
  input logic SRST,
  input logic CTRL,
  n64_joybus_sniffer_if.slave bus
);
  localparam int W = RESP_BYTES * 8;
  localparam int RW = $clog2(W);
  localparam int BW = RW > 4 ? RW : 4;
  localparam int XW = W > 16 ? W : 16;
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RESP = 2'd2} state_t;
  state_t state;
  logic [2:0] hist;
  logic [CNT_W-1:0] wait_cnt, low_cnt;
  logic [BW-1:0] bit_cnt;
  logic [7:0] cmd;
  logic [W-2:0] shreg;
  logic [W-1:0] word;
  logic ne, pe, sat, bit_v, last, cap, igr_match;
  assign ne = hist[2] & ~hist[1];
  assign pe = ~hist[2] & hist[1];
  assign sat = &wait_cnt;
  assign bit_v = low_cnt < wait_cnt;
  assign last = bit_cnt == BW'(W - 1);
  assign word = {bit_v, shreg};
  assign cap = state == RESP && !sat && ne && last;
  // only the low 16 bits take part; narrower words compare against a zero-extended value
  assign igr_match = ~|((XW'(word) ^ XW'(bus.igr_pattern)) & XW'(16'hFFFF));
  assign bus.state_o = state;
  always_ff @(posedge CLK_4M or posedge SRST)
    if (SRST) begin
      state <= IDLE;
      hist <= 3'b111;
      wait_cnt <= '0;
      low_cnt <= '0;
      bit_cnt <= '0;
      cmd <= '0;
      shreg <= '0;
      bus.ctrl_data <= '0;
      bus.data_valid <= 1'b0;
      bus.overrun <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.igr_hit <= 1'b0;
    end else begin
      hist <= {hist[1:0], CTRL};
      wait_cnt <= (ne | pe) ? '0 : sat ? wait_cnt : wait_cnt + 1'b1;
      bus.overrun <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.igr_hit <= 1'b0;
      bus.data_valid <= cap | (bus.data_valid & ~bus.ack);
      if (pe && state != IDLE) low_cnt <= wait_cnt;
      if (cap) begin
        bus.ctrl_data <= word;
        bus.overrun <= bus.data_valid & ~bus.ack;
        bus.igr_hit <= bus.igr_en & igr_match;
      end
      case (state)
        IDLE:
          if (ne && sat) begin
            state <= CMD;
            bit_cnt <= '0;
          end
        CMD:
          if (sat) begin
            bus.frame_err <= 1'b1;
            state <= IDLE;
          end else if (ne) begin
            if (bit_cnt == BW'(8)) begin
              state <= cmd == CMD_POLL ? RESP : IDLE;
              bit_cnt <= '0;
              shreg <= '0;
            end else begin
              cmd <= {cmd[6:0], bit_v};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        RESP:
          if (sat) begin
            bus.frame_err <= 1'b1;
            state <= IDLE;
          end else if (ne) begin
            shreg <= word[W-1:1];
            bit_cnt <= bit_cnt + 1'b1;
            if (last) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_n64_joybus_sniffer.sv
// tb_n64_joybus_sniffer: directed frame vectors and corner sequences for the Joybus sniffer
`timescale 1ns/1ps
module tb_n64_joybus_sniffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl = 1'b1;
  always #125 clk = ~clk;
  n64_joybus_sniffer_if #(.RESP_BYTES(4)) b4();
  n64_joybus_sniffer_if #(.RESP_BYTES(3)) b3();
  n64_joybus_sniffer #(.CNT_W(6), .RESP_BYTES(4), .CMD_POLL(8'h01)) dut4 (
    .CLK_4M(clk), .SRST(rst), .CTRL(ctrl), .bus(b4.slave));
  n64_joybus_sniffer #(.CNT_W(6), .RESP_BYTES(3), .CMD_POLL(8'h01)) dut3 (
    .CLK_4M(clk), .SRST(rst), .CTRL(ctrl), .bus(b3.slave));
  int total = 0, bad = 0;
  int n_ov = 0, n_fe = 0, n_igr = 0, n_igr_dv = 0;
  always @(negedge clk) begin
    if (b4.overrun) n_ov++;
    if (b4.frame_err) n_fe++;
    if (b4.igr_hit) n_igr++;
    if (b4.igr_hit && b4.data_valid) n_igr_dv++;
  end
  typedef struct {
    logic [7:0] cmd;
    logic [31:0] word;
    logic igr_en;
    logic cap;
    logic [31:0] exp_data;
    logic exp_igr;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    ctrl = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic v);
    hold(1'b0, v ? 4 : 12);
    hold(1'b1, v ? 12 : 4);
  endtask
  // the ack strobe lands on the clock edge that registers the capture
  task automatic frame(input logic [7:0] c, input logic [31:0] w, input int nb,
                       input int idle, input logic ack_cap);
    hold(1'b1, idle);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    send_bit(1'b1);
    for (int i = 0; i < nb; i++) send_bit(w[i]);
    ctrl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    b4.ack = ack_cap;
    @(negedge clk);
    b4.ack = 1'b0;
    @(negedge clk);
    hold(1'b1, 8);
  endtask
  task automatic ack_pulse();
    b4.ack = 1'b1;
    @(negedge clk);
    b4.ack = 1'b0;
    @(negedge clk);
  endtask
  int ov0, fe0, ig0, igd0;
  initial begin
    tv[0] = '{8'h01, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0};
    tv[1] = '{8'h00, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
    tv[2] = '{8'h01, 32'h0000_3030, 1'b1, 1'b1, 32'h0000_3030, 1'b1};
    tv[3] = '{8'h01, 32'h0000_3030, 1'b0, 1'b1, 32'h0000_3030, 1'b0};
    tv[4] = '{8'h01, 32'hFFFF_3031, 1'b1, 1'b1, 32'hFFFF_3031, 1'b0};
    tv[5] = '{8'h80, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_3031, 1'b0};
    tv[6] = '{8'h01, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
    tv[7] = '{8'h01, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0};
    b4.ack = 1'b0; b4.igr_en = 1'b0; b4.igr_pattern = 16'h3030;
    b3.ack = 1'b0; b3.igr_en = 1'b0; b3.igr_pattern = 16'h3030;
    repeat (3) @(negedge clk);
    chk("rst_data", 64'(b4.ctrl_data), 0);
    chk("rst_valid", 64'(b4.data_valid), 0);
    chk("rst_overrun", 64'(b4.overrun), 0);
    chk("rst_frame_err", 64'(b4.frame_err), 0);
    chk("rst_igr", 64'(b4.igr_hit), 0);
    chk("rst_state", 64'(b4.state_o), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ack_pulse();
      ov0 = n_ov; fe0 = n_fe; ig0 = n_igr; igd0 = n_igr_dv;
      b4.igr_en = tv[i].igr_en;
      frame(tv[i].cmd, tv[i].word, 32, 80, 1'b0);
      chk($sformatf("v%0d_valid", i), 64'(b4.data_valid), 64'(tv[i].cap));
      chk($sformatf("v%0d_data", i), 64'(b4.ctrl_data), 64'(tv[i].exp_data));
      chk($sformatf("v%0d_igr", i), 64'(n_igr - ig0), 64'(tv[i].exp_igr));
      chk($sformatf("v%0d_igr_dv", i), 64'(n_igr_dv - igd0), 64'(tv[i].exp_igr));
      chk($sformatf("v%0d_frame_err", i), 64'(n_fe - fe0), 0);
      chk($sformatf("v%0d_overrun", i), 64'(n_ov - ov0), 0);
      chk($sformatf("v%0d_state", i), 64'(b4.state_o), 0);
    end
    b4.igr_en = 1'b0;
    ack_pulse();
    ov0 = n_ov;
    frame(8'h01, 32'h1111_1111, 32, 80, 1'b0);
    frame(8'h01, 32'h2222_2222, 32, 80, 1'b0);
    chk("ovr_count", 64'(n_ov - ov0), 1);
    chk("ovr_data", 64'(b4.ctrl_data), 64'h2222_2222);
    chk("ovr_valid", 64'(b4.data_valid), 1);
    ov0 = n_ov;
    frame(8'h01, 32'h3333_3333, 32, 80, 1'b1);
    chk("ackcap_overrun", 64'(n_ov - ov0), 0);
    chk("ackcap_valid", 64'(b4.data_valid), 1);
    chk("ackcap_data", 64'(b4.ctrl_data), 64'h3333_3333);
    ack_pulse();
    chk("lone_ack_valid", 64'(b4.data_valid), 0);
    ack_pulse();
    chk("idle_ack_valid", 64'(b4.data_valid), 0);
    chk("idle_ack_data", 64'(b4.ctrl_data), 64'h3333_3333);
    fe0 = n_fe;
    hold(1'b1, 80);
    for (int i = 7; i >= 0; i--) send_bit(i == 0);
    send_bit(1'b1);
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    hold(1'b0, 80);
    hold(1'b1, 8);
    chk("tmo_frame_err", 64'(n_fe - fe0), 1);
    chk("tmo_data", 64'(b4.ctrl_data), 64'h3333_3333);
    chk("tmo_valid", 64'(b4.data_valid), 0);
    chk("tmo_state", 64'(b4.state_o), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("p3_rst_data", 64'(b3.ctrl_data), 0);
    frame(8'h01, 32'h00AB_CDEF, 24, 80, 1'b0);
    chk("p3_data", 64'(b3.ctrl_data), 64'hAB_CDEF);
    chk("p3_valid", 64'(b3.data_valid), 1);
    hold(1'b1, 80);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    chk("p3_mid_cmd_state", 64'(b3.state_o), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("srst_data", 64'(b3.ctrl_data), 0);
    chk("srst_valid", 64'(b3.data_valid), 0);
    chk("srst_state", 64'(b3.state_o), 0);
    chk("srst_frame_err", 64'(b3.frame_err), 0);
    chk("srst_b4_data", 64'(b4.ctrl_data), 0);
    rst = 1'b0;
    frame(8'h01, 32'h0012_3456, 24, 10, 1'b0);
    chk("short_idle_valid", 64'(b3.data_valid), 0);
    chk("short_idle_data", 64'(b3.ctrl_data), 0);
    chk("short_idle_state", 64'(b3.state_o), 0);
    frame(8'h01, 32'h005A_5A5A, 24, 80, 1'b0);
    chk("post_rst_data", 64'(b3.ctrl_data), 64'h5A_5A5A);
    chk("post_rst_valid", 64'(b3.data_valid), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
